cv32e40s_alert_escalator: RTL
=============================

// Module: cv32e40s_alert_escalator
// PURPOSE
// Parametrised alert combiner/escalator between the core's security checkers and the alert_minor_o/alert_major_o outputs.
// Registers N_MINOR minor and N_MAJOR major trigger sources and keeps a sticky per-source cause record.
// Counts repeated minor events in a leaky counter and escalates to a major alert when the count reaches ESC_THRESH.
// PARAMETERS
// N_MINOR      4    number of minor alert sources (>=1)
// N_MAJOR      8    number of major alert sources (>=1)
// ESC_THRESH   8    minor-event count that escalates to major (>=1); 0 is illegal
// LEAK_PERIOD  256  consecutive event-free cycles per counter decrement (>=2)
// CNT_W        $clog2(ESC_THRESH+1)   minor counter width (derived, not overridable)
// PORTS
// clk            in   1        clock
// rst_n          in   1        asynchronous active-low reset
// minor_src_i    in   N_MINOR  minor triggers, level, sampled every cycle
// major_src_i    in   N_MAJOR  major triggers, level, sampled every cycle
// minor_en_i     in   N_MINOR  per-source enable mask for minor triggers
// clr_i          in   1        single-cycle clear of sticky causes, counter and escalation
// alert_minor_o  out  1        registered minor alert
// alert_major_o  out  1        registered major alert
// minor_cnt_o    out  CNT_W    current leaky minor-event count
// major_cause_o  out  N_MAJOR+1  sticky causes; [N_MAJOR-1:0] = major sources, [N_MAJOR] = escalation
// escalated_o    out  1        high while FSM is in ESCALATED
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n). All flops clear on reset.
// - Reset values: every output is 0, the FSM is in IDLE and the leak timer is 0. Reset mid-operation discards all state.
// - minor_ev = |(minor_src_i & minor_en_i). major_ev = |major_src_i. Major sources have no mask and cannot be disabled.
// - alert_minor_o <= minor_ev. Latency is 1 cycle, and the output follows the level every cycle in every state.
// - alert_major_o <= major_ev | esc_fire. Latency is 1 cycle.
// - esc_fire is the combinational pulse on the IDLE/COUNTING->ESCALATED transition.
// - FSM states IDLE, COUNTING, ESCALATED. State changes take effect on the next edge:
//   IDLE:      minor_ev -> cnt=1, COUNTING. If ESC_THRESH==1, go straight to ESCALATED with esc_fire.
//   COUNTING:  minor_ev -> cnt+1. If cnt+1==ESC_THRESH -> ESCALATED, esc_fire, cnt held at ESC_THRESH.
//              Otherwise leak timer expiry -> cnt-1. If cnt-1 reaches 0 -> IDLE.
//   ESCALATED: sticky. No counting and no leaking. Left only by clr_i or reset, going to IDLE with cnt=0.
// - Leak timer: counts cycles without minor_ev in COUNTING. It resets to 0 on every minor_ev, on a state change and on clr_i.
//   When it reaches LEAK_PERIOD-1 it produces one decrement and restarts from 0.
// - Counter saturates: at most +1 per cycle, however many sources are active. It never exceeds ESC_THRESH and never underflows.
// - major_cause_o[i] <= major_cause_o[i] | major_src_i[i]. Bit [N_MAJOR] is set by esc_fire.
// - clr_i: zeroes major_cause_o, cnt, the leak timer and escalated_o, and sends the FSM to IDLE.
//   Same-cycle event wins over clear: a cause or minor_ev present with clr_i is applied after the clear (cause set, cnt=1 / COUNTING).
// - clr_i does not suppress alert_minor_o or alert_major_o for events in the same cycle.
// - escalated_o and minor_cnt_o are registered state. They are visible the cycle after the causing edge, together with alert_major_o.
// TESTING
// 1. Reset with all triggers high, then deassert rst_n -> all outputs 0 for the first cycle after release, then alerts follow 1 cycle later.
// 2. major_src_i[3] pulsed 1 cycle -> alert_major_o=1 for exactly 1 cycle, 1 cycle later; major_cause_o[3] stays 1 until clr_i.
// 3. ESC_THRESH=8, minor_src_i[0] held 8 cycles -> minor_cnt_o 1..8, then alert_major_o one-cycle pulse, major_cause_o[8]=1, escalated_o=1.
// 4. minor_en_i[2]=0, minor_src_i[2]=1 -> no alert_minor_o, cnt stays 0. With all 4 sources high together -> cnt increments by 1 only.
// 5. LEAK_PERIOD=4, 3 minor events then idle -> cnt 3->2->1->0 every 4 cycles, FSM back to IDLE, alert_major_o never asserted.
// 6. In ESCALATED, clr_i with major_src_i[0]=1 in the same cycle -> escalated_o=0, cnt=0, major_cause_o=0x001, alert_major_o=1.

Source files
------------

// File: rtl/cv32e40s_alert_escalator.sv
`default_nettype none
// ============================================================================
//  Module   : cv32e40s_alert_escalator
//  Purpose  : Combines minor/major security alerts, keeps sticky major causes
//             and escalates bursts of minor events through a leaky counter.
//  Revision : 1.0 - initial release
// ============================================================================
module cv32e40s_alert_escalator #(
  parameter  int unsigned N_MINOR     = 4,
  parameter  int unsigned N_MAJOR     = 8,
  parameter  int unsigned ESC_THRESH  = 8,
  parameter  int unsigned LEAK_PERIOD = 256,
  localparam int unsigned CNT_W       = $clog2(ESC_THRESH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_MINOR-1:0] minor_src_i,
  input  logic [N_MAJOR-1:0] major_src_i,
  input  logic [N_MINOR-1:0] minor_en_i,
  input  logic               clr_i,
  output logic               alert_minor_o,
  output logic               alert_major_o,
  output logic [CNT_W-1:0]   minor_cnt_o,
  output logic [N_MAJOR:0]   major_cause_o,
  output logic               escalated_o
);

  localparam int unsigned     LEAK_W    = $clog2(LEAK_PERIOD);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(ESC_THRESH);
  localparam logic [LEAK_W-1:0] LEAK_ONE  = LEAK_W'(1);
  localparam logic [LEAK_W-1:0] LEAK_LAST = LEAK_W'(LEAK_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTING  = 2'd1,
    ESCALATED = 2'd2
  } state_e;

  state_e              state_q, state_d, state_base;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_base;
  logic [LEAK_W-1:0]   leak_q, leak_d, leak_base;
  logic [N_MAJOR:0]    cause_q, cause_d;
  logic                alert_minor_q, alert_major_q;
  logic                minor_ev, major_ev, esc_fire;

  assign minor_ev = |(minor_src_i & minor_en_i);
  assign major_ev = |major_src_i;

  // Next-state logic: clear is applied first, then the current cycle's event
  // is evaluated against the cleared state so a same-cycle event is not lost.
  always_comb begin
    state_base = clr_i ? IDLE : state_q;
    cnt_base   = clr_i ? '0   : cnt_q;
    leak_base  = clr_i ? '0   : leak_q;
    state_d    = state_base;
    cnt_d      = cnt_base;
    leak_d     = '0;
    esc_fire   = 1'b0;

    case (state_base)
      IDLE: begin
        if (minor_ev) begin
          cnt_d = CNT_ONE;
          if (ESC_THRESH == 1) begin
            state_d  = ESCALATED;
            esc_fire = 1'b1;
          end else begin
            state_d  = COUNTING;
          end
        end
      end
      COUNTING: begin
        if (minor_ev) begin
          // At most one increment per cycle regardless of how many sources fire.
          if (cnt_base == (CNT_MAX - CNT_ONE)) begin
            state_d  = ESCALATED;
            esc_fire = 1'b1;
            cnt_d    = CNT_MAX;
          end else begin
            cnt_d    = cnt_base + CNT_ONE;
          end
        end else if (leak_base == LEAK_LAST) begin
          // Leak one event; timer restarts from zero (leak_d default).
          cnt_d = cnt_base - CNT_ONE;
          if (cnt_base == CNT_ONE) begin
            state_d = IDLE;
          end
        end else begin
          leak_d = leak_base + LEAK_ONE;
        end
      end
      ESCALATED: begin
        // Sticky until clear or reset; no counting and no leaking.
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    cause_d = (clr_i ? '0 : cause_q) | {esc_fire, major_src_i};
  end

  // State, counter, leak timer, sticky causes and registered alerts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      leak_q        <= '0;
      cause_q       <= '0;
      alert_minor_q <= 1'b0;
      alert_major_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      leak_q        <= leak_d;
      cause_q       <= cause_d;
      alert_minor_q <= minor_ev;
      alert_major_q <= major_ev | esc_fire;
    end
  end

  assign alert_minor_o = alert_minor_q;
  assign alert_major_o = alert_major_q;
  assign minor_cnt_o   = cnt_q;
  assign major_cause_o = cause_q;
  assign escalated_o   = (state_q == ESCALATED);

endmodule
`default_nettype wire
